// File: rtl/mantissa_divide_24bit_pkg.sv
// Shared definitions for the mantissa datapath: operand and quotient widths
// and the state encoding of the iterative divider.
package fpalu_pkg;

    localparam int MANT_W = 24;
    localparam int QUOT_W = MANT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/mantissa_divide_24bit_if.sv
// Operand/result bundle of the mantissa divider. The master presents
// operands and consumes results; the slave is the divider itself.
interface mantissa_divide_24bit_if #(
    parameter int WIDTH = 24
);

    logic             valid_data_in;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic [WIDTH-1:0] out;
    logic             guard;
    logic             sticky;
    logic             exp_dec;
    logic             div_by_zero;
    logic             valid_data_out;

    modport master (
        output valid_data_in, dividend, divisor,
        input  ready, out, guard, sticky, exp_dec, div_by_zero, valid_data_out
    );

    modport slave (
        input  valid_data_in, dividend, divisor,
        output ready, out, guard, sticky, exp_dec, div_by_zero, valid_data_out
    );

endinterface

// File: rtl/mantissa_divide_24bit_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift.
// Purely combinational so wider-radix variants can chain several copies.
module mantissa_div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH+2:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH+2:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH+2:0] div_ext;
    logic [WIDTH+2:0] diff;

    assign div_ext = {3'b000, divisor_i};
    assign diff    = rem_i - div_ext;
    assign q_bit_o = (rem_i >= div_ext);

    // The remainder never reaches 2*divisor, so the top bit dropped by the shift is always 0.
    assign rem_o = q_bit_o ? {diff[WIDTH+1:0], 1'b0} : {rem_i[WIDTH+1:0], 1'b0};

endmodule

// File: rtl/mantissa_divide_24bit.sv
// Iterative radix-2 restoring divider for 1.23 mantissas, one quotient bit per
// cycle, producing a normalized quotient with guard/sticky and exponent-decrement flag.
module mantissa_divide_24bit
    import fpalu_pkg::*;
#(
    parameter int WIDTH = MANT_W,
    parameter int QBITS = WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    mantissa_divide_24bit_if.slave  bus
);

    localparam int REM_W = WIDTH + 3;
    localparam int CNT_W = $clog2(QBITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);

    div_state_t       state_q;
    logic [WIDTH-1:0] divisor_q;
    logic [REM_W-1:0] rem_q;
    logic [QBITS-1:0] q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic [WIDTH-1:0] out_q;
    logic             guard_q;
    logic             sticky_q;
    logic             exp_dec_q;
    logic             dbz_q;
    logic             valid_out_q;

    logic [REM_W-1:0] rem_step;
    logic             q_bit;

    logic [WIDTH-1:0] out_d;
    logic             guard_d;
    logic             sticky_d;
    logic             exp_dec_d;
    logic             dbz_d;

    mantissa_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_step),
        .q_bit_o   (q_bit)
    );

    // Quotient lies in (0.5, 2): a single conditional left shift normalizes it.
    always_comb begin
        out_d     = '0;
        guard_d   = 1'b0;
        sticky_d  = 1'b0;
        exp_dec_d = 1'b0;
        dbz_d     = 1'b0;
        if (divisor_q == '0) begin
            out_d = '1;
            dbz_d = 1'b1;
        end else if (q_q[QBITS-1]) begin
            out_d    = q_q[QBITS-1:2];
            guard_d  = q_q[1];
            sticky_d = q_q[0] | (|rem_q);
        end else begin
            out_d     = q_q[QBITS-2:1];
            guard_d   = q_q[0];
            sticky_d  = |rem_q;
            exp_dec_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            divisor_q   <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            out_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            exp_dec_q   <= 1'b0;
            dbz_q       <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.valid_data_in) begin
                        divisor_q <= bus.divisor;
                        rem_q     <= {3'b000, bus.dividend};
                        q_q       <= '0;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    q_q   <= {q_q[QBITS-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    out_q       <= out_d;
                    guard_q     <= guard_d;
                    sticky_q    <= sticky_d;
                    exp_dec_q   <= exp_dec_d;
                    dbz_q       <= dbz_d;
                    valid_out_q <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready          = ready_q;
    assign bus.out            = out_q;
    assign bus.guard          = guard_q;
    assign bus.sticky         = sticky_q;
    assign bus.exp_dec        = exp_dec_q;
    assign bus.div_by_zero    = dbz_q;
    assign bus.valid_data_out = valid_out_q;

endmodule

// File: tb/tb_mantissa_divide_24bit.sv
// Self-checking bench: integer-division reference model with a per-cycle
// compare process, directed literal cases and randomized operand pairs.
module tb_mantissa_divide_24bit;
    import fpalu_pkg::*;

    localparam int LAT = 27;

    typedef struct packed {
        logic [23:0] mant;
        logic        guard;
        logic        sticky;
        logic        exp_dec;
        logic        dz;
    } res_t;

    typedef struct {
        int          acc;
        logic [23:0] a;
        logic [23:0] b;
        res_t        res;
    } op_t;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        res_t        exp;
    } dir_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mantissa_divide_24bit_if #(.WIDTH(24)) bus ();

    mantissa_divide_24bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    logic rst_s = 1'b0;
    logic vin_s = 1'b0;
    logic [23:0] a_s = '0;
    logic [23:0] b_s = '0;
    bit   ready_prev = 1'b1;
    res_t last = '0;
    op_t  pend[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Quotient from exact integer division of a*2^25 by b, then normalized.
    function automatic res_t model(input logic [23:0] a, input logic [23:0] b);
        res_t r;
        logic [63:0] num;
        logic [63:0] q;
        logic [63:0] rm;
        r = '0;
        if (b == 24'd0) begin
            r.mant = 24'hFFFFFF;
            r.dz   = 1'b1;
            return r;
        end
        num = {40'd0, a} << 25;
        q   = num / {40'd0, b};
        rm  = num % {40'd0, b};
        if (q >= 64'h2000000) begin
            r.mant   = q[25:2];
            r.guard  = q[1];
            r.sticky = q[0] | (rm != 0);
        end else begin
            r.mant    = q[24:1];
            r.guard   = q[0];
            r.sticky  = (rm != 0);
            r.exp_dec = 1'b1;
        end
        return r;
    endfunction

    function automatic res_t dut_res();
        return {bus.out, bus.guard, bus.sticky, bus.exp_dec, bus.div_by_zero};
    endfunction

    always @(posedge clk) begin
        edge_cnt++;
        rst_s = rst;
        vin_s = bus.valid_data_in;
        a_s   = bus.dividend;
        b_s   = bus.divisor;
    end

    always @(negedge clk) begin
        bit  due;
        bit  rdy;
        op_t op;
        due = 1'b0;
        if (!rst_s) begin
            pend.delete();
            last = '0;
        end else begin
            due = (pend.size() > 0) && (edge_cnt - pend[0].acc == LAT);
            if (due) begin
                op   = pend.pop_front();
                last = op.res;
                $display("op a=%h b=%h -> out=%h g=%0d s=%0d e=%0d dz=%0d", op.a, op.b,
                         bus.out, bus.guard, bus.sticky, bus.exp_dec, bus.div_by_zero);
            end
            if (vin_s && ready_prev) begin
                op.acc = edge_cnt;
                op.a   = a_s;
                op.b   = b_s;
                op.res = model(a_s, b_s);
                pend.push_back(op);
            end
        end
        rdy = (pend.size() == 0);
        chk("valid_data_out", 64'(bus.valid_data_out), 64'(due));
        chk("ready", 64'(bus.ready), 64'(rdy));
        chk("result", 64'(dut_res()), 64'(last));
        ready_prev = rdy;
    end

    // Presents one operand pair for one accept edge and waits for its pulse.
    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          output res_t r, output int lat);
        int start;
        bus.valid_data_in = 1'b1;
        bus.dividend      = a;
        bus.divisor       = b;
        @(posedge clk);
        #1;
        start = edge_cnt;
        bus.valid_data_in = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid_data_out) begin
                lat = edge_cnt - start;
                break;
            end
        end
        r = dut_res();
    endtask

    dir_t dir[6];

    initial begin
        res_t r;
        int   lat;
        int   pulses;
        logic [23:0] a;
        logic [23:0] b;
        int   hold;

        dir[0] = '{24'h800000, 24'h800000, {24'h800000, 1'b0, 1'b0, 1'b0, 1'b0}};
        dir[1] = '{24'h800000, 24'hC00000, {24'hAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0}};
        dir[2] = '{24'hC00000, 24'h800000, {24'hC00000, 1'b0, 1'b0, 1'b0, 1'b0}};
        dir[3] = '{24'hFFFFFF, 24'h800000, {24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        dir[4] = '{24'h900000, 24'h000000, {24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
        dir[5] = '{24'h800000, 24'h800000, {24'h800000, 1'b0, 1'b0, 1'b0, 1'b0}};

        bus.valid_data_in = 1'b0;
        bus.dividend      = '0;
        bus.divisor       = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(bus.ready), 64'd1);
        chk("reset_result", 64'(dut_res()), 64'd0);

        // Directed cases, each presented during the previous result pulse.
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            run_op(dir[i].a, dir[i].b, r, lat);
            chk($sformatf("dir%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("dir%0d_result", i), 64'(r), 64'(dir[i].exp));
        end
        bus.valid_data_in = 1'b0;

        // valid held high while busy must not queue a second operation.
        @(posedge clk);
        #1;
        bus.valid_data_in = 1'b1;
        bus.dividend      = 24'hC00000;
        bus.divisor       = 24'hC00000;
        repeat (20) @(posedge clk);
        #1 bus.valid_data_in = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.valid_data_out) pulses++;
        end
        chk("held_valid_pulses", 64'(pulses), 64'd1);

        // Reset at iteration 10 aborts the run.
        @(posedge clk);
        #1;
        bus.valid_data_in = 1'b1;
        bus.dividend      = 24'hA00000;
        bus.divisor       = 24'hE00000;
        @(posedge clk);
        #1 bus.valid_data_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_result", 64'(dut_res()), 64'd0);
        pulses = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (bus.valid_data_out) pulses++;
        end
        chk("abort_pulses", 64'(pulses), 64'd0);
        run_op(24'h800000, 24'hC00000, r, lat);
        chk("after_abort_latency", 64'(lat), 64'(LAT));
        chk("after_abort_result", 64'(r), 64'({24'hAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0}));

        // Randomized operands, sometimes with valid held across a whole run.
        for (int i = 0; i < 30; i++) begin
            a = 24'h800000 | 24'($urandom & 32'h7FFFFF);
            b = 24'h800000 | 24'($urandom & 32'h7FFFFF);
            if ($urandom_range(0, 9) == 0) b = 24'h000000;
            hold = $urandom_range(1, 32);
            @(posedge clk);
            #1;
            bus.valid_data_in = 1'b1;
            bus.dividend      = a;
            bus.divisor       = b;
            repeat (hold) @(posedge clk);
            #1 bus.valid_data_in = 1'b0;
            for (int k = 0; k < 80 && pend.size() != 0; k++) @(negedge clk);
            chk("random_drain", 64'(pend.size()), 64'd0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mantissa_divide_24bit.md
Name: mantissa_divide_24bit

Overview:
- Iterative radix-2 restoring divider for 24-bit normalized mantissas in 1.23 format, hidden bit included.
- It is the exact-division counterpart to the reciprocal path. It produces the quotient mantissa of the FP divide together with guard/sticky bits and a normalization flag.
- It consumes the same valid_data_in / valid_data_out, 24-bit mantissa interface as the rest of the mantissa datapath. Its results are used for the exact path and for cross-checking reciprocal-based division.

Parameters:
- WIDTH, 24, mantissa width including hidden bit.
- QBITS, WIDTH+2, quotient bits generated: 1 integer bit + WIDTH-1 fraction bits + guard + one extra bit.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-low.
- valid_data_in  input  1  operands valid; accepted only when ready=1.
- dividend  input  WIDTH  mantissa a, 1.23.
- divisor  input  WIDTH  mantissa b, 1.23.
- ready  output  1  block idle, can accept new operands.
- out  output  WIDTH  normalized quotient mantissa, 1.23.
- guard  output  1  first bit below out LSB.
- sticky  output  1  OR of all lower quotient bits and nonzero final remainder.
- exp_dec  output  1  quotient was < 1; exponent must be decremented by 1.
- div_by_zero  output  1  divisor == 0.
- valid_data_out  output  1  one-cycle pulse; outputs valid.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, ready=1, out=0, guard=0, sticky=0, exp_dec=0, div_by_zero=0, valid_data_out=0. Reset applies mid-operation too: the run aborts and no valid_data_out is issued.
- States are IDLE, RUN and DONE.
- IDLE:
  - ready=1.
  - On valid_data_in=1: latch divisor; rem <= {3'b0, dividend} (WIDTH+3 bits); q <= 0; cnt <= 0; go to RUN.
- RUN:
  - ready=0. Each cycle: if rem >= {3'b0, divisor}, shift 1 into q LSB and set rem <= (rem - divisor) << 1; otherwise shift 0 into q and set rem <= rem << 1.
  - cnt increments each cycle. After QBITS iterations (cnt == QBITS-1), go to DONE.
- DONE:
  - Register the outputs and pulse valid_data_out=1 for exactly this cycle, then return to IDLE.
  - If q[QBITS-1]=1: out=q[QBITS-1:2], guard=q[1], sticky=q[0] | (rem!=0), exp_dec=0.
  - Else: out=q[QBITS-2:1], guard=q[0], sticky=(rem!=0), exp_dec=1.
  - Outputs hold their values until the next DONE or reset.
- Latency: operands accepted at edge N; valid_data_out is high during the cycle following edge N+QBITS+1, i.e. 27 cycles after accept for the defaults. Throughput is one operation per QBITS+2 cycles.
- valid_data_in while ready=0 is ignored (no queuing, no error). valid_data_in in the DONE cycle is ignored; it is accepted on the next cycle in IDLE.
- Precondition: dividend[WIDTH-1]=1 and divisor[WIDTH-1]=1. With this precondition the quotient lies in (0.5, 2), so one normalization shift suffices.
- divisor==0: div_by_zero=1, out={WIDTH{1'b1}}, guard=0, sticky=0, exp_dec=0. Latency is unchanged, and div_by_zero clears on the next result.
- The subtractor is WIDTH+3 bits wide. The remainder stays < 2*divisor before the shift, so no overflow is possible.

Decomposition:
- Shared package fpalu_pkg holds:
  - MANT_W=24 and QUOT_W=26.
  - Enum div_state_t {IDLE, RUN, DONE}.
- One natural sub-module, mantissa_div_step: a combinational compare/subtract/shift producing next rem and the quotient bit. Keep it separate so a radix-4 variant can reuse it later.
- The counter, FSM and output normalization stay in the top module.

Test Plan:
- dividend=0x800000, divisor=0x800000 -> out=0x800000, guard=0, sticky=0, exp_dec=0, valid_data_out exactly 27 cycles after accept.
- dividend=0x800000, divisor=0xC00000 (1/1.5) -> out=0xAAAAAA, guard=1, sticky=1, exp_dec=1.
- dividend=0xC00000, divisor=0x800000 -> out=0xC00000, guard=0, sticky=0, exp_dec=0; dividend=0xFFFFFF, divisor=0x800000 -> out=0xFFFFFF, guard=0, sticky=0, exp_dec=0.
- Second valid_data_in held high while ready=0 -> ignored, exactly one valid_data_out pulse. Second operand pair presented the cycle after DONE -> accepted, second pulse 27 cycles later.
- rst=0 for one cycle at iteration 10 -> no valid_data_out, all outputs 0, ready=1 the cycle after rst returns high. A fresh operation then completes correctly.
- divisor=0x000000, dividend=0x900000 -> div_by_zero=1, out=0xFFFFFF, same latency. Next normal divide clears div_by_zero.
